// File: rtl/cache_definitions_pkg.sv
// Shared types for the cache controller and its backing memory model.
package cache_definitions_pkg;

  localparam int MEM_LATENCY_DEFAULT = 4;
  localparam int LINE_W              = 128;

  typedef struct packed {
    logic [31:0]       addr;
    logic [LINE_W-1:0] data;
    logic              rw;
    logic              valid;
  } mem_req_t;

  typedef struct packed {
    logic [LINE_W-1:0] data;
    logic              ready;
  } mem_data_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } mem_model_state_t;

endpackage

// File: rtl/dm_mem_array.sv
// Single-port line store: synchronous write, asynchronous read at the same index.
module dm_mem_array
  import cache_definitions_pkg::*;
#(
  parameter int LINES = 4096,
  parameter int IDX_W = $clog2(LINES)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [LINE_W-1:0] wdata,
  output logic [LINE_W-1:0] rdata
);

  // NOTE: the array has no reset; its contents must survive a controller reset.
  logic [LINE_W-1:0] mem [LINES];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/dm_mem_model.sv
// Fixed-latency line memory answering the direct-mapped cache controller.
module dm_mem_model
  import cache_definitions_pkg::*;
#(
  parameter int LATENCY   = MEM_LATENCY_DEFAULT,
  parameter int MEM_LINES = 4096
) (
  input  logic      clk,
  input  logic      reset,
  input  mem_req_t  mem_req,
  output mem_data_t mem_data,
  output logic      busy
);

  localparam int               IDX_W        = $clog2(MEM_LINES);
  localparam logic [3:0]       CNT_LOAD     = 4'(LATENCY - 1);
  localparam mem_model_state_t ACCEPT_STATE = (LATENCY == 1) ? RESP : WAIT;

  mem_model_state_t  state, state_next;
  logic [3:0]        cnt, cnt_next;
  logic [IDX_W-1:0]  idx_q;
  logic [LINE_W-1:0] wdata_q, rd_data;
  logic              rw_q, ready_q, busy_q;
  logic              accept, commit;
  logic              unused_addr_bits;

  // Offset and tag bits above the line index are don't-care: addresses alias.
  assign unused_addr_bits = ^{mem_req.addr[31:IDX_W+4], mem_req.addr[3:0]};

  assign accept = mem_req.valid && (state == IDLE || state == RESP);
  // A reset at the edge closing RESP aborts the write before it lands.
  assign commit = (state == RESP) && rw_q && !reset;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    unique case (state)
      IDLE: if (mem_req.valid) begin
        state_next = ACCEPT_STATE;
        cnt_next   = CNT_LOAD;
      end
      WAIT: begin
        if (cnt == 4'd0) state_next = RESP;
        else             cnt_next   = cnt - 4'd1;
      end
      RESP: begin
        if (mem_req.valid) begin
          state_next = ACCEPT_STATE;
          cnt_next   = CNT_LOAD;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ready/busy are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      ready_q <= (state_next == RESP);
      busy_q  <= (state_next != IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q   <= '0;
      wdata_q <= '0;
      rw_q    <= 1'b0;
    end else if (accept) begin
      idx_q   <= mem_req.addr[IDX_W+3:4];
      wdata_q <= mem_req.data;
      rw_q    <= mem_req.rw;
    end
  end

  dm_mem_array #(
    .LINES (MEM_LINES)
  ) u_array (
    .clk   (clk),
    .we    (commit),
    .idx   (idx_q),
    .wdata (wdata_q),
    .rdata (rd_data)
  );

  always_comb begin
    mem_data.ready = ready_q;
    mem_data.data  = '0;
    if (ready_q) mem_data.data = rw_q ? wdata_q : rd_data;
    busy = busy_q;
  end

endmodule

// File: tb/tb_dm_mem_model.sv
// Directed plus randomized bench for dm_mem_model at LATENCY 4 and 1.
module tb_dm_mem_model;
  import cache_definitions_pkg::*;

  localparam int LAT    = 4;
  localparam int LINES  = 4096;
  localparam int RESP_C = LAT + 1;

  logic      clk = 1'b0;
  logic      reset;
  mem_req_t  req4, req1;
  mem_data_t rsp4, rsp1;
  logic      busy4, busy1;

  int n_cmp = 0;
  int n_err = 0;

  logic [127:0] ref_mem [LINES];
  logic [127:0] pend_exp;
  logic [11:0]  pend_idx;
  logic         pend_w;

  always #5 clk = ~clk;

  dm_mem_model #(.LATENCY(LAT), .MEM_LINES(LINES)) dut4 (
    .clk      (clk),
    .reset    (reset),
    .mem_req  (req4),
    .mem_data (rsp4),
    .busy     (busy4)
  );

  dm_mem_model #(.LATENCY(1), .MEM_LINES(LINES)) dut1 (
    .clk      (clk),
    .reset    (reset),
    .mem_req  (req1),
    .mem_data (rsp1),
    .busy     (busy1)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Line index by the aliasing rule: byte address / 16, modulo the line count.
  function automatic logic [11:0] idx_of(input logic [31:0] a);
    return 12'((a / 32'd16) % LINES);
  endfunction

  task automatic issue(input logic [31:0] a, input logic [127:0] d, input logic w);
    req4.addr  = a;
    req4.data  = d;
    req4.rw    = w;
    req4.valid = 1'b1;
    pend_idx   = idx_of(a);
    pend_w     = w;
    pend_exp   = w ? d : ref_mem[pend_idx];
  endtask

  // Ready must appear exactly LAT edges after the accepting edge, busy throughout.
  task automatic await_resp(input string tag, input bit hold);
    for (int c = 1; c <= RESP_C; c++) begin
      @(negedge clk);
      if ((c == 1 && !hold) || c == RESP_C) req4.valid = 1'b0;
      check({tag, "_ready"}, 128'(rsp4.ready), 128'(c == RESP_C));
      check({tag, "_busy"},  128'(busy4), 128'(1));
      check({tag, "_data"},  rsp4.data, (c == RESP_C) ? pend_exp : 128'd0);
    end
    if (pend_w) ref_mem[pend_idx] = pend_exp;
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    check({tag, "_ready"}, 128'(rsp4.ready), 128'(0));
    check({tag, "_busy"},  128'(busy4), 128'(0));
    check({tag, "_data"},  rsp4.data, 128'd0);
  endtask

  initial begin
    logic [31:0]  a;
    logic [127:0] d;
    logic         w, hold, b2b;

    for (int i = 0; i < LINES; i++) ref_mem[i] = '0;
    reset = 1'b1;
    req4  = '0;
    req1  = '0;
    // Request presented during reset must be dropped.
    req4.addr  = 32'h0000_0060;
    req4.data  = {4{32'h5555_5555}};
    req4.rw    = 1'b1;
    req4.valid = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ready", 128'(rsp4.ready), 128'(0));
    check("rst_busy",  128'(busy4), 128'(0));
    check("rst_data",  rsp4.data, 128'd0);
    check("rst_busy1", 128'(busy1), 128'(0));
    reset      = 1'b0;
    req4.valid = 1'b0;
    idle_check("post_rst");

    issue(32'h0000_0010, {4{32'h1111_1111}}, 1'b1);
    await_resp("wr10", 1'b0);
    idle_check("wr10_idle");
    issue(32'h0000_0010, '0, 1'b0);
    await_resp("rd10", 1'b0);
    idle_check("rd10_idle");
    issue(32'h0001_0010, '0, 1'b0);
    await_resp("rd10_alias", 1'b0);
    check("alias_val", pend_exp, {4{32'h1111_1111}});
    idle_check("alias_idle");

    // Back-to-back: read issued in the write's response cycle.
    issue(32'h0000_0020, {4{32'hAAAA_AAAA}}, 1'b1);
    await_resp("wr20", 1'b0);
    issue(32'h0000_0020, '0, 1'b0);
    await_resp("rd20_b2b", 1'b0);
    check("b2b_val", pend_exp, {4{32'hAAAA_AAAA}});
    idle_check("b2b_idle");

    // Reset two cycles after accepting a write aborts it.
    issue(32'h0000_0030, {4{32'hDEAD_BEEF}}, 1'b1);
    @(negedge clk);
    req4.valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_ready", 128'(rsp4.ready), 128'(0));
    check("abort_busy",  128'(busy4), 128'(0));
    check("abort_data",  rsp4.data, 128'd0);
    reset = 1'b0;
    repeat (3) idle_check("post_abort");
    issue(32'h0000_0030, '0, 1'b0);
    await_resp("rd30", 1'b0);
    idle_check("rd30_idle");
    issue(32'h0000_0060, '0, 1'b0);
    await_resp("rd60", 1'b0);
    idle_check("rd60_idle");

    // Valid held through WAIT must not cause a second acceptance.
    issue(32'h0000_0010, '0, 1'b0);
    await_resp("rd_hold", 1'b1);
    idle_check("hold_idle1");
    idle_check("hold_idle2");

    // LATENCY=1 instance: response in the cycle right after acceptance.
    req1.addr = 32'h0000_0040; req1.data = '0; req1.rw = 1'b0; req1.valid = 1'b1;
    @(negedge clk);
    req1.valid = 1'b0;
    check("l1_rd_ready", 128'(rsp1.ready), 128'(1));
    check("l1_rd_busy",  128'(busy1), 128'(1));
    check("l1_rd_data",  rsp1.data, 128'd0);
    @(negedge clk);
    check("l1_idle_ready", 128'(rsp1.ready), 128'(0));
    check("l1_idle_busy",  128'(busy1), 128'(0));
    req1.data = {4{32'h0123_4567}}; req1.rw = 1'b1; req1.valid = 1'b1;
    @(negedge clk);
    check("l1_wr_ready", 128'(rsp1.ready), 128'(1));
    check("l1_wr_data",  rsp1.data, {4{32'h0123_4567}});
    req1.data = '0; req1.rw = 1'b0;
    @(negedge clk);
    req1.valid = 1'b0;
    check("l1_rb_ready", 128'(rsp1.ready), 128'(1));
    check("l1_rb_data",  rsp1.data, {4{32'h0123_4567}});
    @(negedge clk);
    check("l1_end_ready", 128'(rsp1.ready), 128'(0));
    check("l1_end_busy",  128'(busy1), 128'(0));

    // Randomized traffic over a few lines, aliased tags, optional back-to-back.
    for (int i = 0; i < 24; i++) begin
      a    = ($urandom & 32'hFFFF_000F) | (32'($urandom_range(0, 7)) << 4);
      d    = {$urandom, $urandom, $urandom, $urandom};
      w    = 1'($urandom_range(0, 1));
      hold = 1'($urandom_range(0, 1));
      b2b  = 1'($urandom_range(0, 1));
      if (!b2b) idle_check("rnd_gap");
      issue(a, d, w);
      await_resp("rnd", hold);
    end
    idle_check("rnd_end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
